// File: rtl/arb_pkg.sv
// arb_pkg: shared entry layout, mode encodings and burst-count helper for the arbiter FIFO read side.
package arb_pkg;
    localparam int PV_W = 8;
    localparam int ARB_DW = 32;
    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_SLV0 = 2'b01;
    localparam logic [1:0] MODE_SLV1 = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef struct packed {
        logic              source;
        logic [1:0]        mode;
        logic [PV_W-1:0]   proc_val;
        logic [ARB_DW-1:0] data;
    } arb_entry_t;

    // Remaining-beat count after a delivered beat; a zero length counts as one beat.
    function automatic logic [PV_W-1:0] burst_next(input logic [PV_W-1:0] cnt, input logic [PV_W-1:0] pv);
        return cnt != '0 ? cnt - 1'b1 : (pv != '0 ? pv - 1'b1 : '0);
    endfunction
endpackage

// File: rtl/drain_buf.sv
// drain_buf: 2-entry in-order skid buffer; slot0 is always the head.
module drain_buf #(
    parameter int W = 41
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic [1:0]   occ
);
    logic [W-1:0] slot0, slot1;
    logic [1:0]   wr_idx;

    assign wr_idx     = occ - {1'b0, pop};
    assign head_valid = occ != 2'd0;
    assign head_data  = slot0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ   <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop) slot0 <= slot1;
            if (push && wr_idx == 2'd0) slot0 <= push_data;
            if (push && wr_idx == 2'd1) slot1 <= push_data;
        end
    end
endmodule

// File: rtl/arb_fifo_drain.sv
// arb_fifo_drain: pops arbiter FIFO entries, filters by mode, routes by source tag
// and pulses per-source completion when a burst is fully delivered.
module arb_fifo_drain import arb_pkg::*; #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    input  logic [DW+10:0] fifo_rd_data,
    output logic [DW-1:0] mstr0_data,
    output logic [DW-1:0] mstr1_data,
    output logic          mstr0_valid,
    output logic          mstr1_valid,
    input  logic          mstr0_ready,
    input  logic          mstr1_ready,
    output logic          mstr0_cmplt,
    output logic          mstr1_cmplt,
    output logic          mode_err
);
    localparam int BW = DW + 1 + PV_W;

    logic            rd_q, push, pop, head_valid, beat0, beat1;
    logic [1:0]      occ;
    logic [2:0]      credit_used;
    logic [BW-1:0]   head;
    logic            in_src, h_src;
    logic [1:0]      in_mode;
    logic [PV_W-1:0] in_pv, h_pv, cnt0, cnt1, nxt0, nxt1;
    logic [DW-1:0]   in_data, h_data;

    assign {in_src, in_mode, in_pv, in_data} = fifo_rd_data;
    assign push = rd_q & (in_mode == MODE_SLV0 || in_mode == MODE_SLV1);

    drain_buf #(.W(BW)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  ({in_src, in_pv, in_data}),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head),
        .occ        (occ)
    );

    assign {h_src, h_pv, h_data} = head;
    assign mstr0_valid = head_valid & ~h_src;
    assign mstr1_valid = head_valid & h_src;
    assign mstr0_data  = mstr0_valid ? h_data : '0;
    assign mstr1_data  = mstr1_valid ? h_data : '0;
    assign beat0       = mstr0_valid & mstr0_ready;
    assign beat1       = mstr1_valid & mstr1_ready;
    assign pop         = beat0 | beat1;

    // The in-flight read reserves a slot even if its mode later drops it.
    assign credit_used = {1'b0, occ} - {2'b0, pop} + {2'b0, rd_q};
    assign fifo_rd_en  = rst_n & ~fifo_empty & (credit_used < 3'd2);

    assign nxt0 = burst_next(cnt0, h_pv);
    assign nxt1 = burst_next(cnt1, h_pv);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q        <= 1'b0;
            mode_err    <= 1'b0;
            cnt0        <= '0;
            cnt1        <= '0;
            mstr0_cmplt <= 1'b0;
            mstr1_cmplt <= 1'b0;
        end else begin
            rd_q        <= fifo_rd_en;
            mode_err    <= mode_err | (rd_q & in_mode == MODE_RSVD);
            if (beat0) cnt0 <= nxt0;
            if (beat1) cnt1 <= nxt1;
            mstr0_cmplt <= beat0 & (nxt0 == '0);
            mstr1_cmplt <= beat1 & (nxt1 == '0);
        end
    end
endmodule

// File: tb/tb_arb_fifo_drain.sv
// tb_arb_fifo_drain: directed checks of arb_fifo_drain against a behavioural FIFO and an event log.
module tb_arb_fifo_drain;
    import arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [42:0] fifo_rd_data = '0;
    logic [31:0] mstr0_data, mstr1_data;
    logic        mstr0_valid, mstr1_valid;
    logic        mstr0_ready = 1'b0;
    logic        mstr1_ready = 1'b0;
    logic        mstr0_cmplt, mstr1_cmplt, mode_err;

    typedef struct packed {
        logic [15:0] cyc;
        logic [1:0]  kind;
        logic        src;
        logic [31:0] data;
    } ev_t;

    arb_entry_t mem [64];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;
    int         pops = 0;
    int         rd_start = -1;
    logic       do_pop = 1'b0;
    logic       prev_rd = 1'b0;
    ev_t        evq [$];
    int         checks = 0;
    int         errors = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    arb_fifo_drain #(.DW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .mstr0_data   (mstr0_data),
        .mstr1_data   (mstr1_data),
        .mstr0_valid  (mstr0_valid),
        .mstr1_valid  (mstr1_valid),
        .mstr0_ready  (mstr0_ready),
        .mstr1_ready  (mstr1_ready),
        .mstr0_cmplt  (mstr0_cmplt),
        .mstr1_cmplt  (mstr1_cmplt),
        .mode_err     (mode_err)
    );

    always #5 clk = ~clk;

    // FIFO model: data for a pop appears just after the edge that sampled fifo_rd_en.
    always @(posedge clk) begin
        do_pop = fifo_rd_en;
        if (do_pop && !prev_rd) rd_start = cyc;
        prev_rd = do_pop;
        if (do_pop) pops++;
        cyc++;
        #1;
        if (do_pop) begin
            fifo_rd_data = mem[rd_ptr];
            rd_ptr++;
        end
    end

    // Event log: completion pulses first, then delivered beats, stamped with the cycle.
    always @(negedge clk) begin
        if (mstr0_cmplt) evq.push_back(ev_t'{cyc[15:0], 2'd2, 1'b0, 32'h0});
        if (mstr1_cmplt) evq.push_back(ev_t'{cyc[15:0], 2'd2, 1'b1, 32'h0});
        if (mstr0_valid && mstr0_ready) evq.push_back(ev_t'{cyc[15:0], 2'd1, 1'b0, mstr0_data});
        if (mstr1_valid && mstr1_ready) evq.push_back(ev_t'{cyc[15:0], 2'd1, 1'b1, mstr1_data});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic s, input logic [1:0] m, input logic [7:0] pv, input logic [31:0] d);
        mem[wr_ptr] = arb_entry_t'{source: s, mode: m, proc_val: pv, data: d};
        wr_ptr++;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ev_chk(input string tag, input int idx, input int c, input logic [1:0] k,
                          input logic s, input logic [31:0] d);
        ev_t got, exp;
        exp = ev_t'{c[15:0], k, s, d};
        got = (idx < evq.size()) ? evq[idx] : '0;
        chk(tag, 64'(got), 64'(exp));
    endtask

    initial begin
        int t, base, pbase;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_ctrl", 64'({fifo_rd_en, mstr0_valid, mstr1_valid, mstr0_cmplt, mstr1_cmplt, mode_err}), 64'h0);
        end
        chk("reset_data", 64'({mstr0_data, mstr1_data}), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step();
            chk("empty_idle", 64'({fifo_rd_en, mstr0_valid, mstr1_valid}), 64'h0);
        end

        // Streaming on source 0, one burst of 8.
        mstr0_ready = 1'b1;
        base = evq.size();
        for (int i = 0; i < 8; i++) push(1'b0, MODE_SLV0, 8'd8, 32'h10 + i);
        repeat (14) step();
        t = rd_start;
        chk("stream_count", 64'(evq.size() - base), 64'd9);
        for (int i = 0; i < 8; i++) ev_chk("stream_beat", base + i, t + 2 + i, 2'd1, 1'b0, 32'h10 + i);
        ev_chk("stream_cmplt", base + 8, t + 10, 2'd2, 1'b0, 32'h0);

        // Interleaved sources.
        mstr1_ready = 1'b1;
        base = evq.size();
        push(1'b0, MODE_SLV0, 8'd2, 32'hA0);
        push(1'b0, MODE_SLV0, 8'd2, 32'hA1);
        push(1'b1, MODE_SLV1, 8'd1, 32'hB0);
        push(1'b0, MODE_SLV0, 8'd0, 32'hA2);
        repeat (10) step();
        t = rd_start;
        chk("inter_count", 64'(evq.size() - base), 64'd7);
        ev_chk("inter_a0", base + 0, t + 2, 2'd1, 1'b0, 32'hA0);
        ev_chk("inter_a1", base + 1, t + 3, 2'd1, 1'b0, 32'hA1);
        ev_chk("inter_c0a", base + 2, t + 4, 2'd2, 1'b0, 32'h0);
        ev_chk("inter_b0", base + 3, t + 4, 2'd1, 1'b1, 32'hB0);
        ev_chk("inter_c1", base + 4, t + 5, 2'd2, 1'b1, 32'h0);
        ev_chk("inter_a2", base + 5, t + 5, 2'd1, 1'b0, 32'hA2);
        ev_chk("inter_c0b", base + 6, t + 6, 2'd2, 1'b0, 32'h0);

        // Backpressure: master 0 stalls for several cycles during a 4-word burst.
        mstr0_ready = 1'b0;
        base = evq.size();
        pbase = pops;
        for (int i = 0; i < 4; i++) push(1'b0, MODE_SLV0, 8'd4, 32'hC0 + i);
        repeat (5) step();
        t = rd_start;
        chk("bp_pops", 64'(pops - pbase), 64'd2);
        chk("bp_hold1", 64'({mstr0_valid, mstr1_valid, mstr0_data}), {31'h0, 1'b1, 1'b0, 32'hC0});
        step();
        chk("bp_hold2", 64'({mstr0_valid, mstr1_valid, mstr0_data}), {31'h0, 1'b1, 1'b0, 32'hC0});
        chk("bp_no_beat", 64'(evq.size() - base), 64'd0);
        mstr0_ready = 1'b1;
        repeat (8) step();
        chk("bp_pops_all", 64'(pops - pbase), 64'd4);
        chk("bp_count", 64'(evq.size() - base), 64'd5);
        for (int i = 0; i < 4; i++) ev_chk("bp_beat", base + i, t + 6 + i, 2'd1, 1'b0, 32'hC0 + i);
        ev_chk("bp_cmplt", base + 4, t + 10, 2'd2, 1'b0, 32'h0);

        // Mode filter: idle and reserved entries are dropped.
        base = evq.size();
        push(1'b0, MODE_IDLE, 8'd1, 32'h33);
        push(1'b0, MODE_RSVD, 8'd1, 32'h44);
        push(1'b0, MODE_SLV0, 8'd1, 32'h55);
        step();
        step();
        t = rd_start;
        chk("mode_err_before", 64'(mode_err), 64'd0);
        step();
        chk("mode_err_set", 64'(mode_err), 64'd1);
        repeat (5) step();
        chk("mode_err_sticky", 64'(mode_err), 64'd1);
        chk("mode_count", 64'(evq.size() - base), 64'd2);
        ev_chk("mode_beat", base + 0, t + 4, 2'd1, 1'b0, 32'h55);
        ev_chk("mode_cmplt", base + 1, t + 5, 2'd2, 1'b0, 32'h0);

        // Reset with two words buffered for a stalled master 1.
        mstr1_ready = 1'b0;
        push(1'b1, MODE_SLV1, 8'd2, 32'hD0);
        push(1'b1, MODE_SLV1, 8'd2, 32'hD1);
        repeat (5) step();
        chk("rst_pre_valid", 64'({mstr1_valid, mstr1_data}), {31'h0, 1'b1, 32'hD0});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 64'({fifo_rd_en, mstr0_valid, mstr1_valid, mstr0_cmplt, mstr1_cmplt, mode_err}), 64'h0);
        chk("rst_mid_data", 64'({mstr0_data, mstr1_data}), 64'h0);
        repeat (2) step();
        base = evq.size();
        rst_n = 1'b1;
        mstr1_ready = 1'b1;
        repeat (10) step();
        chk("rst_no_replay", 64'(evq.size() - base), 64'd0);
        chk("rst_idle", 64'({mstr0_valid, mstr1_valid, fifo_rd_en}), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb_fifo_drain.md
# arb_fifo_drain

Read side of the arbiter FIFO: pops entries that the arbiter wrote (data, mode, processing length, source tag), filters them by mode, and returns each word to the master port matching its source tag (0 or 1) over a valid/ready handshake. Tracks per-source burst length from the processing-length field and pulses that source's completion strobe (`mstr0_cmplt`/`mstr1_cmplt`, the signals the arbiter gates on) when the burst is fully delivered.

## Interface
- `DW`, 32, data word width
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `fifo_empty`  in  1  FIFO has no entries
- `fifo_rd_en`  out  1  pop request; data valid exactly 1 cycle later
- `fifo_rd_data`  in  DW+11  {source[1], mode[2], proc_val[8], data[DW]}, MSB first
- `mstr0_data` / `mstr1_data`  out  DW  word to master 0 / 1
- `mstr0_valid` / `mstr1_valid`  out  1  word present
- `mstr0_ready` / `mstr1_ready`  in  1  master accepts
- `mstr0_cmplt` / `mstr1_cmplt`  out  1  one-cycle pulse, burst done
- `mode_err`  out  1  sticky; set on reserved mode 2'b11, cleared only by reset

## Operation
- Modes: 2'b01 (slv0 traffic) and 2'b10 (slv1 traffic) are forwarded; 2'b00 dropped silently; 2'b11 dropped and sets `mode_err`. Dropped entries consume no buffer slot and do not touch burst counters.
- Routing uses the source bit only: source 0 -> master 0, source 1 -> master 1.
- 2-entry in-order buffer between FIFO and outputs. Only the head entry is presented; its valid is driven on the port selected by its source, and the other port's valid is 0.
- Credit rule: `fifo_rd_en` = ~`fifo_empty` & (occupancy + in-flight reads < 2), where occupancy is counted after this cycle's pop. Never pop when `fifo_empty`=1.
- Burst tracking: one 8-bit remaining counter per source. On a delivered beat when the counter is 0, load `proc_val`-1 (`proc_val`=0 treated as 1). Otherwise decrement.
- When a delivered beat leaves its counter at 0, the matching `cmplt` pulses on the next cycle.
- Head-of-line blocking is intentional: a stalled master stalls the other source too, which preserves arbiter order.

## Timing
- Reset values: `fifo_rd_en`=0, both valids 0, both data buses 0, both cmplt 0, `mode_err`=0; buffer, in-flight flag, and counters cleared.
- Latency: `fifo_rd_en` at cycle N gives a valid output at N+2 (N+1 capture, N+2 present); an empty buffer passes the word through in 2 cycles.
- Throughput: 1 word/cycle sustained while the FIFO is non-empty and the target ready is held high.
- Handshake: beat transfers when valid & ready. While valid=1 and ready=0, data and valid stay stable. Valid never depends combinationally on ready.
- Simultaneous capture and pop with the buffer full: legal; the credit rule prevents overflow.
- Burst of one beat (`proc_val`=0 or 1): cmplt pulses the cycle after that beat.
- Back-to-back bursts on the same source: the counter reloads on the next beat and cmplt pulses per burst.
- Reset asserted mid-burst: all outputs go to reset values immediately; any in-flight FIFO data is discarded. The FIFO's own reset is the integrator's responsibility.

## Structure
- `arb_pkg`: `arb_entry_t` packed struct {source, mode, proc_val, data}, mode constants `MODE_IDLE/MODE_SLV0/MODE_SLV1/MODE_RSVD`, `PV_W`=8.
- Sub-module `drain_buf`: parameterized 2-entry FIFO-order skid buffer with occupancy output. The top level holds the credit logic, mode filter, routing, counters, and cmplt generation.

## Test plan
- Reset mid-traffic: assert `rst_n`=0 with 2 words buffered -> all outputs 0 the same cycle; after release, nothing is replayed.
- Streaming: 8 entries {src0, 01, pv=8, data=0x10..0x17}, `mstr0_ready`=1 -> 8 consecutive beats 0x10..0x17 starting 2 cycles after the first `fifo_rd_en`; one `mstr0_cmplt` pulse the cycle after 0x17; `mstr1_valid` stays 0.
- Interleaved sources: src0 pv=2 (0xA0,0xA1), then src1 pv=1 (0xB0), then src0 pv=0 (0xA2) -> order A0,A1,B0,A2; `mstr0_cmplt` after A1 and after A2; `mstr1_cmplt` after B0.
- Backpressure: `mstr0_ready`=0 for 5 cycles during a 4-word stream -> at most 2 pops; data held stable; no word lost or duplicated after ready returns.
- Mode filter: entries with mode 00, 11, then 01 (data 0x55) -> only 0x55 delivered; `mode_err`=1 from the cycle after the 11 entry is captured and stays 1.
- Empty FIFO: `fifo_empty`=1 for 20 cycles -> `fifo_rd_en` stays 0 and no valid is asserted.
